// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM memory test engine and its models:
// controller states, lane geometry and the fill/merge data patterns.
package bram_test_pkg;

  localparam int C_NB_COL     = 4;
  localparam int C_COL_WIDTH  = 8;
  localparam int C_DATA_WIDTH = C_NB_COL * C_COL_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_MERGE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [C_DATA_WIDTH-1:0] pat(input logic [31:0] seed,
                                                  input logic [31:0] a);
    return seed ^ a ^ (a << 16);
  endfunction

  // Fill pattern with lane a[1:0] inverted, i.e. memory contents after the merge pass
  function automatic logic [C_DATA_WIDTH-1:0] exp(input logic [31:0] seed,
                                                  input logic [31:0] a);
    logic [C_DATA_WIDTH-1:0] lane;
    lane = {{(C_DATA_WIDTH-C_COL_WIDTH){1'b0}}, {C_COL_WIDTH{1'b1}}} << (C_COL_WIDTH * a[1:0]);
    return pat(seed, a) ^ lane;
  endfunction

endpackage

// File: rtl/bram_memtest_master_if.sv
// Dual-port BRAM word interface: port 1 read/write, port 2 read-only.
interface bram_memtest_master_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int NB_COL     = 4
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d;
  logic                  we;
  logic [NB_COL-1:0]     bytesel;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH-1:0] addr2;
  logic [DATA_WIDTH-1:0] d2;
  logic                  we2;
  logic [NB_COL-1:0]     bytesel2;
  logic [DATA_WIDTH-1:0] q2;

  modport master (
    output addr, d, we, bytesel, addr2, d2, we2, bytesel2,
    input  q, q2
  );

  modport slave (
    input  addr, d, we, bytesel, addr2, d2, we2, bytesel2,
    output q, q2
  );

endinterface

// File: rtl/bram_memtest_cmp.sv
// Registered two-port read-back comparator: aligns expected data with the
// one-clock read latency, counts mismatches (saturating), records the first one.
module bram_memtest_cmp
  import bram_test_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter int          DATA_WIDTH = 32,
  parameter int          ERR_WIDTH  = 16,
  parameter logic [31:0] SEED       = 32'hAABBCCDD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [ADDR_WIDTH-1:0] i_addr2,
  input  logic [DATA_WIDTH-1:0] i_q1,
  input  logic [DATA_WIDTH-1:0] i_q2,
  output logic [ERR_WIDTH-1:0]  o_err_count,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic                  o_fail_port,
  output logic [DATA_WIDTH-1:0] o_fail_data
);

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH-1:0] r_addr2;
  logic [DATA_WIDTH-1:0] r_exp1;
  logic [DATA_WIDTH-1:0] r_exp2;
  logic [ERR_WIDTH-1:0]  r_errCount;
  logic                  r_captured;
  logic [ADDR_WIDTH-1:0] r_failAddr;
  logic                  r_failPort;
  logic [DATA_WIDTH-1:0] r_failData;

  logic                  w_miss1;
  logic                  w_miss2;
  logic [ERR_WIDTH:0]    w_sum;
  logic [ERR_WIDTH-1:0]  w_errNext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_exp1  <= '0;
      r_exp2  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_addr1 <= i_addr1;
      r_addr2 <= i_addr2;
      r_exp1  <= DATA_WIDTH'(exp(SEED, 32'(i_addr1)));
      r_exp2  <= DATA_WIDTH'(exp(SEED, 32'(i_addr2)));
    end
  end

  assign w_miss1   = r_valid && (i_q1 != r_exp1);
  assign w_miss2   = r_valid && (i_q2 != r_exp2);
  assign w_sum     = {1'b0, r_errCount} + (ERR_WIDTH+1)'(w_miss1) + (ERR_WIDTH+1)'(w_miss2);
  assign w_errNext = w_sum[ERR_WIDTH] ? '1 : w_sum[ERR_WIDTH-1:0];

  // Port 1 wins when both ports miss on the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errCount <= '0;
      r_captured <= 1'b0;
      r_failAddr <= '0;
      r_failPort <= 1'b0;
      r_failData <= '0;
    end else if (i_clear) begin
      r_errCount <= '0;
      r_captured <= 1'b0;
      r_failAddr <= '0;
      r_failPort <= 1'b0;
      r_failData <= '0;
    end else begin
      r_errCount <= w_errNext;
      if (!r_captured && (w_miss1 || w_miss2)) begin
        r_captured <= 1'b1;
        r_failAddr <= w_miss1 ? r_addr1 : r_addr2;
        r_failPort <= !w_miss1;
        r_failData <= w_miss1 ? i_q1 : i_q2;
      end
    end
  end

  assign o_err_count = r_errCount;
  assign o_fail_addr = r_failAddr;
  assign o_fail_port = r_failPort;
  assign o_fail_data = r_failData;

endmodule

// File: rtl/bram_memtest_master.sv
// BRAM bring-up test engine: fills a word region, rewrites one inverted lane per
// word, then reads the region back on both ports and reports the result.
module bram_memtest_master
  import bram_test_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter int          NB_COL     = 4,
  parameter int          COL_WIDTH  = 8,
  parameter logic [31:0] SEED       = 32'hAABBCCDD,
  parameter int          ERR_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [ADDR_WIDTH-1:0]     i_last_addr,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_pass,
  output logic [ERR_WIDTH-1:0]      o_err_count,
  output logic [ADDR_WIDTH-1:0]     o_fail_addr,
  output logic                      o_fail_port,
  output logic [NB_COL*COL_WIDTH-1:0] o_fail_data,
  bram_memtest_master_if.master     bus
);

  localparam int DW = NB_COL * COL_WIDTH;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_nextPtr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  r_bad;
  logic                  w_nextBad;
  logic                  r_drain;
  logic                  w_nextDrain;

  logic                  w_accept;
  logic                  w_wrap;
  logic [ADDR_WIDTH-1:0] w_ptrNext;
  logic [ADDR_WIDTH-1:0] w_nextAddr2;
  logic [DW-1:0]         w_pat;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_addr2;
  logic [DW-1:0]         w_d;
  logic                  w_we;
  logic [NB_COL-1:0]     w_bytesel;
  logic                  w_rdValid;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr2;
  logic [DW-1:0]         r_d;
  logic                  r_we;
  logic [NB_COL-1:0]     r_bytesel;
  logic                  r_rdValid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;

  logic [ERR_WIDTH-1:0]  w_errCount;

  assign w_accept    = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_wrap      = (r_ptr == r_last);
  assign w_ptrNext   = w_wrap ? r_base : r_ptr + ADDR_WIDTH'(1);
  assign w_nextBad   = w_accept ? (i_base_addr > i_last_addr) : r_bad;
  assign w_nextAddr2 = (w_nextPtr == r_last) ? r_base : w_nextPtr + ADDR_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_base  <= '0;
      r_last  <= '0;
      r_bad   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_bad   <= w_nextBad;
      r_drain <= w_nextDrain;
      if (w_accept) begin
        r_base <= i_base_addr;
        r_last <= i_last_addr;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextDrain = r_drain;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_nextState = ST_FILL;
          w_nextPtr   = i_base_addr;
        end
      end
      ST_FILL: begin
        if (r_bad) begin
          w_nextState = ST_DONE;
        end else begin
          w_nextPtr = w_ptrNext;
          if (w_wrap) w_nextState = ST_MERGE;
        end
      end
      ST_MERGE: begin
        w_nextPtr = w_ptrNext;
        if (w_wrap) w_nextState = ST_READ;
      end
      ST_READ: begin
        w_nextPtr = w_ptrNext;
        if (w_wrap) begin
          w_nextState = ST_DRAIN;
          w_nextDrain = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_nextDrain = 1'b1;
        if (r_drain) w_nextState = ST_DONE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Bus values are decoded from the upcoming state so every strobe leaves a flop
  always_comb begin
    w_addr    = '0;
    w_addr2   = '0;
    w_d       = '0;
    w_we      = 1'b0;
    w_bytesel = '0;
    w_rdValid = 1'b0;
    w_pat     = DW'(pat(SEED, 32'(w_nextPtr)));
    unique case (w_nextState)
      ST_FILL: begin
        if (!w_nextBad) begin
          w_we      = 1'b1;
          w_bytesel = '1;
          w_addr    = w_nextPtr;
          w_d       = w_pat;
        end
      end
      ST_MERGE: begin
        w_we      = 1'b1;
        w_bytesel = NB_COL'(1) << w_nextPtr[1:0];
        w_addr    = w_nextPtr;
        w_d       = ~w_pat;
      end
      ST_READ: begin
        w_addr    = w_nextPtr;
        w_addr2   = w_nextAddr2;
        w_rdValid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_addr2   <= '0;
      r_d       <= '0;
      r_we      <= 1'b0;
      r_bytesel <= '0;
      r_rdValid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_addr    <= w_addr;
      r_addr2   <= w_addr2;
      r_d       <= w_d;
      r_we      <= w_we;
      r_bytesel <= w_bytesel;
      r_rdValid <= w_rdValid;
      r_busy    <= (w_nextState != ST_IDLE) && (w_nextState != ST_DONE);
      r_done    <= (w_nextState == ST_DONE);
      if (w_nextState != ST_DONE) begin
        r_pass <= 1'b0;
      end else if (r_state != ST_DONE) begin
        r_pass <= !r_bad && (w_errCount == '0);
      end
    end
  end

  bram_memtest_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DW),
    .ERR_WIDTH  (ERR_WIDTH),
    .SEED       (SEED)
  ) u_cmp (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_accept),
    .i_valid     (r_rdValid),
    .i_addr1     (r_addr),
    .i_addr2     (r_addr2),
    .i_q1        (bus.q),
    .i_q2        (bus.q2),
    .o_err_count (w_errCount),
    .o_fail_addr (o_fail_addr),
    .o_fail_port (o_fail_port),
    .o_fail_data (o_fail_data)
  );

  assign bus.addr     = r_addr;
  assign bus.d        = r_d;
  assign bus.we       = r_we;
  assign bus.bytesel  = r_bytesel;
  assign bus.addr2    = r_addr2;
  assign bus.d2       = '0;
  assign bus.we2      = 1'b0;
  assign bus.bytesel2 = '0;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = w_errCount;

endmodule

// File: doc/bram_memtest_master.md
Name: bram_memtest_master

Overview:
- Initiator side of the dual-port BRAM/ROM word interface used by the OSD boot ROM blocks.
- Port 1 (addr/d/we/bytesel/q) is read/write; port 2 (addr2/q2) is read-only.
- Self-contained test engine: on start it fills a word region with a known pattern, overwrites one byte lane per word with inverted data, then reads the region back on both ports at once.
- Reports pass/fail, error count and the first failing location. Sits between a control register block and a BRAM instance for bring-up and regression.

Parameters:
ADDR_WIDTH, 14, word address width of both memory ports
NB_COL, 4, byte lanes per word (fixed 4; other values unsupported)
COL_WIDTH, 8, bits per lane; data width = NB_COL*COL_WIDTH = 32
SEED, 32'hAABBCCDD, pattern seed
ERR_WIDTH, 16, error counter width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only when idle
base_addr  in  ADDR_WIDTH  first word of region
last_addr  in  ADDR_WIDTH  last word of region (inclusive)
busy  out  1  test running
done  out  1  result valid; held until next accepted start
pass  out  1  1 when done and err_count==0 and region legal
err_count  out  ERR_WIDTH  mismatches, saturating
fail_addr  out  ADDR_WIDTH  word address of first mismatch
fail_port  out  1  0 = port 1, 1 = port 2 for first mismatch
fail_data  out  32  read data of first mismatch
addr  out  ADDR_WIDTH  port 1 address
d  out  32  port 1 write data
we  out  1  port 1 write enable
bytesel  out  4  port 1 lane enables; bit i covers d[8i+7:8i]
q  in  32  port 1 read data, valid one clk after addr
addr2  out  ADDR_WIDTH  port 2 address
d2  out  32  tied 0
we2  out  1  tied 0
bytesel2  out  4  tied 0
q2  in  32  port 2 read data, valid one clk after addr2

Behaviour:
- Reset (async) values: all outputs 0; state IDLE. Memory strobes drop immediately on reset assertion, including mid-test. Results are cleared.
- All memory-side outputs are registered.
- Pattern, computed mod 2^32:
  - pat(a) = SEED ^ zext(a) ^ (zext(a) << 16)
  - exp(a) = pat(a) with lane a[1:0] replaced by the same lane of ~pat(a)
- next(a) = base_addr if a == last_addr, else a+1.
- N = last_addr − base_addr + 1.
- States: IDLE → FILL → MERGE → READ → DRAIN → DONE → (start) FILL.
- IDLE/DONE:
  - start accepted on edge E0.
  - base_addr/last_addr are latched at E0. done, pass, err_count and fail_* are cleared at E0.
  - busy rises after E0.
  - If base_addr > last_addr: go to DONE at E0+1 with pass=0, err_count=0, no memory cycles.
- FILL: after edges E0..E(N−1), present we=1, bytesel=1111, addr=a, d=pat(a), for a = base..last, one word per clock.
- MERGE: after edges EN..E(2N−1), present we=1, bytesel=1<<a[1:0], d=~pat(a).
- READ: after edges E2N..E(3N−1), present we=0, bytesel=0, addr=a, addr2=next(a).
- Pipeline:
  - Expected values and addresses are delayed one stage to match the 1-clk read latency.
  - Compare q vs exp(a) and q2 vs exp(next(a)) on the edge after data is valid; the compare result is registered.
- DRAIN: 2 clocks, addr/we held 0.
- DONE:
  - done=1 and busy=0 after edge E3N+2.
  - busy is high from E0 through E3N+1 inclusive.
- Errors:
  - Each mismatching port increments err_count by 1, so up to 2 per cycle, saturating at all-ones.
  - fail_* is captured on the first mismatch only. If both ports mismatch in the same cycle, port 1 is recorded.
- start while busy: ignored, no effect on the running test.
- Single-word region (N=1): addr2 = addr = base in READ.
- Address arithmetic wraps only via next(). The region never exceeds 2^ADDR_WIDTH words.

Decomposition:
- Shared package bram_test_pkg: state enum, lane count and width constants, pat()/exp() functions. The BRAM testbench model also uses these.
- One sub-module: bram_memtest_cmp, the registered two-port comparator with saturating counter and first-fail capture.

Test Plan:
- Ideal 1-clk-latency RAM model, base=0, last=3, start at E0:
  - done at E14, pass=1, err_count=0.
  - Word 1 reads pat(1) with lane 1 inverted.
  - Bus trace shows 4 full writes, 4 single-lane writes, 4 dual reads.
- Model forces q/q2 bit 0 inverted whenever word 2 is read, region 0..3:
  - err_count=2, fail_addr=2, fail_port=1 (port 2 reads word 2 first, at a=1), pass=0.
- base=last=5: addr=addr2=5 during READ; done at E5, pass=1.
- Reset asserted mid-FILL (after E2): we/busy drop without waiting for a clock edge.
  - Re-start with base=0, last=3 completes with pass=1.
- start pulsed during READ: ignored, same done timing.
- base=8, last=3: done at E1, pass=0, err_count=0, no we pulses.
- ERR_WIDTH=4, model returns 0 for all reads, region 0..15: err_count saturates at 15, fail_addr=0, fail_port=0.
